// File: rtl/jk_excite_driver.sv
// JK excitation driver: buffers target q bits, drives j/k to a downstream JK
// flip-flop and checks that the flip-flop's q follows each target.
module jk_excite_driver #(
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 8,
  parameter bit DONT_CARE_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             tgt_bit,
  input  logic             q_obs,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s, empty_s, push_s, pop_s, head_s;
  logic             exp_r, exp_nxt_s;
  logic             j_r, k_r;
  logic [1:0]       jk_nxt_s;
  logic             mism_s, err_nxt_s;
  logic [CNT_W-1:0] err_cnt_r, cnt_nxt_s;

  // Excitation table: (current q, target) -> {j, k}; don't-care inputs get DONT_CARE_VAL.
  function automatic logic [1:0] excite(input logic q, input logic t);
    logic [1:0] jk;
    case ({q, t})
      2'b00:   jk = {1'b0, DONT_CARE_VAL};
      2'b01:   jk = {1'b1, DONT_CARE_VAL};
      2'b10:   jk = {DONT_CARE_VAL, 1'b1};
      2'b11:   jk = {DONT_CARE_VAL, 1'b0};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_s    = tgt_valid && !full_s;
  assign head_s    = mem_r[rd_ptr_r];
  assign tgt_ready = !full_s;
  assign busy      = (state_r != IDLE) || !empty_s;
  assign j         = j_r;
  assign k         = k_r;
  assign err_cnt   = err_cnt_r;

  // Target FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= tgt_bit;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and pop decision.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE, CHECK: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE:   state_nxt_s = CHECK;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for j/k, expected q and error reporting.
  always_comb begin
    jk_nxt_s  = 2'b00;
    exp_nxt_s = exp_r;
    if (pop_s) begin
      jk_nxt_s  = excite(q_obs, head_s);
      exp_nxt_s = head_s;
    end else begin
      jk_nxt_s  = 2'b00;
      exp_nxt_s = exp_r;
    end
    mism_s    = (state_r == CHECK) && (q_obs != exp_r);
    err_nxt_s = mism_s;
    if (mism_s && (err_cnt_r != {CNT_W{1'b1}})) begin
      cnt_nxt_s = err_cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_nxt_s = err_cnt_r;
    end
  end

  // Registered outputs and expected-q holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_r       <= 1'b0;
      k_r       <= 1'b0;
      exp_r     <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt_r <= {CNT_W{1'b0}};
    end else begin
      j_r       <= jk_nxt_s[1];
      k_r       <= jk_nxt_s[0];
      exp_r     <= exp_nxt_s;
      err_pulse <= err_nxt_s;
      err_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench: two drivers (default and CNT_W=2/DONT_CARE_VAL=1) share one target
// stream, each driving its own JK flip-flop model whose observed q can be forced low.
module tb_jk_excite_driver;

  logic       clk, rst_n, tgt_valid, tgt_bit;
  logic       tgt_ready_a, j_a, k_a, busy_a, err_pulse_a, q_a, q_obs_a, frc_a;
  logic [7:0] err_cnt_a;
  logic       tgt_ready_b, j_b, k_b, busy_b, err_pulse_b, q_b, q_obs_b, frc_b;
  logic [1:0] err_cnt_b;

  int n_chk;
  int n_fail;

  jk_excite_driver #(.DEPTH(4), .CNT_W(8), .DONT_CARE_VAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_a),
    .tgt_bit(tgt_bit), .q_obs(q_obs_a), .j(j_a), .k(k_a), .busy(busy_a),
    .err_pulse(err_pulse_a), .err_cnt(err_cnt_a));

  jk_excite_driver #(.DEPTH(4), .CNT_W(2), .DONT_CARE_VAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_b),
    .tgt_bit(tgt_bit), .q_obs(q_obs_b), .j(j_b), .k(k_b), .busy(busy_b),
    .err_pulse(err_pulse_b), .err_cnt(err_cnt_b));

  assign q_obs_a = frc_a ? 1'b0 : q_a;
  assign q_obs_b = frc_b ? 1'b0 : q_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_a <= 1'b0;
    else case ({j_a, k_a})
      2'b01:   q_a <= 1'b0;
      2'b10:   q_a <= 1'b1;
      2'b11:   q_a <= ~q_a;
      default: q_a <= q_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_b <= 1'b0;
    else case ({j_b, k_b})
      2'b01:   q_b <= 1'b0;
      2'b10:   q_b <= 1'b1;
      2'b11:   q_b <= ~q_b;
      default: q_b <= q_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic t;
    logic ja, ka, qa;
    logic jb, kb, qb;
  } vec_t;

  vec_t       vt[4];
  logic [7:0] t3;
  logic       acc;
  int         idx, stalls, stall_at, edges, w;

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t3 = 8'b0101_0101;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0; frc_a = 1'b0; frc_b = 1'b0;

    // Reset state
    #1;
    chk("rst_ready", 32'(tgt_ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_jk", 32'({j_a, k_a}), 32'd0);
    chk("rst_err", 32'({err_pulse_a, err_cnt_a}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while in DRIVE abandons the target
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    @(negedge clk); tgt_valid = 1'b0;
    @(negedge clk);
    chk("t1_drive_j", 32'(j_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_jk", 32'({j_a, k_a}), 32'd0);
    chk("t1_ready", 32'(tgt_ready_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd0);
    chk("t1_cnt", 32'(err_cnt_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_no_pulse", 32'({err_pulse_a, busy_a}), 32'd0);
    end

    // Table: targets 1,1,0,0 on both drivers
    for (int i = 0; i < 4; i++) begin
      tgt_valid = 1'b1; tgt_bit = vt[i].t;
      @(negedge clk); tgt_valid = 1'b0;
      @(negedge clk);
      chk("t2_jk_a", 32'({j_a, k_a}), 32'({vt[i].ja, vt[i].ka}));
      chk("t2_jk_b", 32'({j_b, k_b}), 32'({vt[i].jb, vt[i].kb}));
      chk("t2_busy", 32'({busy_a, busy_b}), 32'd3);
      @(negedge clk);
      chk("t2_q_a", 32'(q_a), 32'(vt[i].qa));
      chk("t2_q_b", 32'(q_b), 32'(vt[i].qb));
      chk("t2_jk_idle", 32'({j_a, k_a}), 32'd0);
      @(negedge clk);
      chk("t2_pulse", 32'({err_pulse_a, err_pulse_b}), 32'd0);
    end
    chk("t2_cnt", 32'({err_cnt_a, err_cnt_b}), 32'd0);
    chk("t2_idle", 32'(busy_a), 32'd0);

    // Back-to-back stream filling the FIFO
    idx = 0; stalls = 0; stall_at = -1; edges = 0;
    while (idx < 8 && edges < 40) begin
      tgt_valid = 1'b1; tgt_bit = t3[idx];
      acc = tgt_ready_a;
      if (!acc) begin stalls++; stall_at = edges; end
      @(negedge clk);
      edges++;
      if (acc) idx++;
    end
    tgt_valid = 1'b0;
    chk("t3_pushed", 32'(idx), 32'd8);
    chk("t3_edges", 32'(edges), 32'd9);
    chk("t3_stalls", 32'(stalls), 32'd1);
    chk("t3_stall_at", 32'(stall_at), 32'd7);
    w = 0;
    while (busy_a && w < 30) begin @(negedge clk); w++; end
    chk("t3_busy_fall", 32'(w), 32'd9);
    chk("t3_cnt", 32'({err_cnt_a, err_cnt_b}), 32'd0);
    chk("t3_q", 32'({q_a, q_b}), 32'd0);

    // Forced mismatch on the first of two targets
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    @(negedge clk);
    @(negedge clk); tgt_valid = 1'b0;
    chk("t4_drive", 32'({j_a, k_a}), 32'd2);
    @(negedge clk);
    chk("t4_q", 32'(q_a), 32'd1);
    frc_a = 1'b1;
    @(negedge clk); frc_a = 1'b0;
    chk("t4_pulse", 32'(err_pulse_a), 32'd1);
    chk("t4_cnt", 32'(err_cnt_a), 32'd1);
    chk("t4_next_jk", 32'({j_a, k_a}), 32'd2);
    @(negedge clk);
    chk("t4_pulse_clr", 32'(err_pulse_a), 32'd0);
    @(negedge clk);
    chk("t4_end", 32'({err_pulse_a, busy_a, err_cnt_a}), 32'd1);
    chk("t4_b_cnt", 32'(err_cnt_b), 32'd0);

    // Saturating 2-bit counter on driver B
    frc_b = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tgt_valid = 1'b1; tgt_bit = 1'b1;
      @(negedge clk); tgt_valid = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("t5_pulse", 32'(err_pulse_b), 32'd1);
      chk("t5_cnt", 32'(err_cnt_b), (n > 3) ? 32'd3 : 32'(n));
    end
    frc_b = 1'b0;
    @(negedge clk);
    chk("t5_pulse_clr", 32'(err_pulse_b), 32'd0);
    chk("t5_a_cnt", 32'({err_pulse_a, err_cnt_a}), 32'd1);
    chk("t5_idle", 32'({busy_a, busy_b}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
